// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared CBus types for the cache-bus arbiter.
//   cbus_req_t  : requester -> memory request (one beat view, len/burst for bursts)
//   cbus_resp_t : memory -> requester response (ready per beat, last on final beat)
//   arb_state_t : arbiter ownership state
package cbus_rr_arbiter_pkg;

    localparam logic [1:0] CBUS_BURST_FIXED = 2'b00;
    localparam logic [1:0] CBUS_BURST_INCR  = 2'b01;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strb;
        logic [63:0] data;
        logic [7:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        is_write;
        logic [1:0]  resp;
        logic [63:0] data;
        logic        last;
    } cbus_resp_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/cbus_rr_pick.sv
// Combinational rotating-priority picker.
//   valid     : request vector
//   rr_ptr    : index holding highest priority this round
//   winner    : first valid index scanning rr_ptr, rr_ptr+1, ... mod NUM_INPUTS
//   any_valid : at least one request present
// Holding rr_ptr at 0 turns this into a plain lowest-index-wins picker.
module cbus_rr_pick #(
    parameter int NUM_INPUTS = 2,
    parameter int IDX_W      = $clog2(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] valid,
    input  logic [IDX_W-1:0]      rr_ptr,
    output logic [IDX_W-1:0]      winner,
    output logic                  any_valid
);

    // Each input gets its distance from rr_ptr around the ring; the valid
    // input with the smallest distance wins. Constant loop indices keep the
    // vector selects static, which also handles non-power-of-two sizes.
    always_comb begin
        int best;
        int d;
        best      = NUM_INPUTS;
        d         = 0;
        winner    = '0;
        any_valid = |valid;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (i >= int'(rr_ptr)) d = i - int'(rr_ptr);
            else                   d = i + NUM_INPUTS - int'(rr_ptr);
            if (valid[i] && d < best) begin
                best   = d;
                winner = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// N-way CBus arbiter in front of the single memory port.
//   clk, reset : clock, asynchronous active-high reset
//   ireqs      : per-requester requests (index 0 = requester 0)
//   iresps     : per-requester responses; only the owner ever sees ready/last
//   oreq       : request forwarded to memory, live copy of the owner's request
//   oresp      : memory response, routed to the owner only
// The grant is held from the cycle after arbitration until the beat with
// oresp.ready && oresp.last, then one IDLE cycle precedes the next grant.
module cbus_rr_arbiter
    import cbus_rr_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS     = 2,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  cbus_req_t  [NUM_INPUTS-1:0] ireqs,
    output cbus_resp_t [NUM_INPUTS-1:0] iresps,
    output cbus_req_t                   oreq,
    input  cbus_resp_t                  oresp
);

    localparam int IDX_W = $clog2(NUM_INPUTS);

    arb_state_t            state;
    logic [IDX_W-1:0]      owner;
    logic [IDX_W-1:0]      rr_ptr;
    logic [NUM_INPUTS-1:0] req_valid;
    logic [IDX_W-1:0]      winner;
    logic                  any_valid;
    logic                  txn_done;

    always_comb begin
        req_valid = '0;
        for (int i = 0; i < NUM_INPUTS; i++) req_valid[i] = ireqs[i].valid;
    end

    // In fixed-priority mode rr_ptr is never advanced, so it stays at 0.
    cbus_rr_pick #(
        .NUM_INPUTS (NUM_INPUTS),
        .IDX_W      (IDX_W)
    ) u_pick (
        .valid     (req_valid),
        .rr_ptr    (rr_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    assign txn_done = (state == ARB_BUSY) && oresp.ready && oresp.last;

    // Outputs are pure muxing on registered state: oresp never reaches oreq,
    // and an asynchronous reset clears both sides in the same cycle.
    always_comb begin
        oreq   = '0;
        iresps = '0;
        if (state == ARB_BUSY) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (owner == IDX_W'(i)) begin
                    oreq      = ireqs[i];
                    iresps[i] = oresp;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ARB_IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (any_valid) begin
                        owner <= winner;
                        state <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (txn_done) begin
                        state <= ARB_IDLE;
                        if (FIXED_PRIORITY == 0) begin
                            rr_ptr <= (owner == IDX_W'(NUM_INPUTS - 1)) ? '0
                                                                         : owner + IDX_W'(1);
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
module tb_cbus_rr_arbiter;
    import cbus_rr_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Two-input round-robin instance
    cbus_req_t  [1:0] rq2;
    cbus_resp_t [1:0] rs2;
    cbus_req_t        oq2;
    cbus_resp_t       or2;
    // Three-input round-robin instance
    cbus_req_t  [2:0] rq3;
    cbus_resp_t [2:0] rs3;
    cbus_req_t        oq3;
    cbus_resp_t       or3;
    // Two-input fixed-priority instance
    cbus_req_t  [1:0] rqf;
    cbus_resp_t [1:0] rsf;
    cbus_req_t        oqf;
    cbus_resp_t       orf;

    cbus_rr_arbiter #(.NUM_INPUTS(2), .FIXED_PRIORITY(0)) u_rr2 (
        .clk(clk), .reset(reset), .ireqs(rq2), .iresps(rs2), .oreq(oq2), .oresp(or2));
    cbus_rr_arbiter #(.NUM_INPUTS(3), .FIXED_PRIORITY(0)) u_rr3 (
        .clk(clk), .reset(reset), .ireqs(rq3), .iresps(rs3), .oreq(oq3), .oresp(or3));
    cbus_rr_arbiter #(.NUM_INPUTS(2), .FIXED_PRIORITY(1)) u_fp (
        .clk(clk), .reset(reset), .ireqs(rqf), .iresps(rsf), .oreq(oqf), .oresp(orf));

    // The owner must hold valid until its last beat.
    always @(negedge clk) begin
        if (!reset && u_rr2.state == ARB_BUSY)
            assert (oq2.valid) else $error("FAIL protocol: owner dropped valid while busy");
    end

    function automatic cbus_req_t mk_req(input logic [63:0] a, input logic wr, input logic [7:0] len);
        cbus_req_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.is_write = wr;
        r.size     = 3'd3;
        r.addr     = a;
        r.strb     = wr ? 8'hFF : 8'h00;
        r.len      = len;
        r.burst    = CBUS_BURST_INCR;
        return r;
    endfunction

    function automatic cbus_resp_t mk_beat(input logic [63:0] d, input logic lst);
        cbus_resp_t r;
        r       = '0;
        r.ready = 1'b1;
        r.data  = d;
        r.last  = lst;
        return r;
    endfunction

    task automatic nxt(); @(posedge clk); #1; endtask
    task automatic smp(); @(negedge clk); endtask

    task automatic test_reset();
        reset = 1'b1;
        rq2 = '0; rq3 = '0; rqf = '0;
        or2 = '0; or3 = '0; orf = '0;
        rq2[0] = mk_req(64'h8000_0000, 1'b0, 8'd0);
        or2    = mk_beat(64'h1, 1'b1);
        nxt(); smp();
        vec_cnt++; if (oq2 !== '0) begin err_cnt++; $display("FAIL reset_oreq2 got %h want 0", oq2); end
        vec_cnt++; if (rs2 !== '0) begin err_cnt++; $display("FAIL reset_iresps2 got %h want 0", rs2); end
        vec_cnt++; if (oq3 !== '0 || rs3 !== '0) begin err_cnt++; $display("FAIL reset_rr3 got %h/%h want 0", oq3, rs3); end
        vec_cnt++; if (oqf !== '0 || rsf !== '0) begin err_cnt++; $display("FAIL reset_fp got %h/%h want 0", oqf, rsf); end
        nxt();
        rq2 = '0; or2 = '0; reset = 1'b0;
    endtask

    task automatic test_single();
        cbus_resp_t beat;
        beat = mk_beat(64'h1234_5678, 1'b1);
        nxt(); rq2[1] = mk_req(64'h8000_0000, 1'b0, 8'd0); smp();               // cycle 0
        vec_cnt++; if (oq2.valid !== 1'b0) begin err_cnt++; $display("FAIL single_c0 valid got %b want 0", oq2.valid); end
        nxt(); smp();                                                          // cycle 1
        vec_cnt++; if (oq2 !== rq2[1]) begin err_cnt++; $display("FAIL single_c1 oreq got %h want %h", oq2, rq2[1]); end
        vec_cnt++; if (rs2 !== '0) begin err_cnt++; $display("FAIL single_c1 iresps got %h want 0", rs2); end
        nxt(); smp();                                                          // cycle 2
        nxt(); or2 = beat; smp();                                              // cycle 3
        vec_cnt++; if (rs2[1] !== beat) begin err_cnt++; $display("FAIL single_c3 iresps1 got %h want %h", rs2[1], beat); end
        vec_cnt++; if (rs2[0] !== '0) begin err_cnt++; $display("FAIL single_c3 iresps0 got %h want 0", rs2[0]); end
        nxt(); rq2[1] = '0; or2 = '0; smp();                                   // cycle 4
        vec_cnt++; if (oq2 !== '0 || u_rr2.state !== ARB_IDLE) begin err_cnt++; $display("FAIL single_c4 idle got %h/%0d want 0/IDLE", oq2, u_rr2.state); end
    endtask

    task automatic test_simultaneous();
        nxt();                                                                 // cycle 0
        rq2[0] = mk_req(64'h8000_1000, 1'b0, 8'd0);
        rq2[1] = mk_req(64'h8000_2000, 1'b0, 8'd0);
        nxt(); smp();                                                          // cycle 1
        vec_cnt++; if (oq2.addr !== 64'h8000_1000 || oq2.valid !== 1'b1) begin err_cnt++; $display("FAIL simul_first addr got %h want 80001000", oq2.addr); end
        nxt(); nxt();                                                          // cycles 2,3
        nxt(); or2 = mk_beat(64'hAA, 1'b1); smp();                             // cycle 4
        vec_cnt++; if (rs2[0].ready !== 1'b1 || rs2[1] !== '0) begin err_cnt++; $display("FAIL simul_c4 ready got %b/%h want 1/0", rs2[0].ready, rs2[1]); end
        nxt(); rq2[0] = '0; or2 = '0; smp();                                   // cycle 5
        vec_cnt++; if (oq2.valid !== 1'b0) begin err_cnt++; $display("FAIL simul_bubble valid got %b want 0", oq2.valid); end
        nxt(); smp();                                                          // cycle 6
        vec_cnt++; if (oq2.addr !== 64'h8000_2000 || oq2.valid !== 1'b1) begin err_cnt++; $display("FAIL simul_second addr got %h want 80002000", oq2.addr); end
        or2 = mk_beat(64'hBB, 1'b1);
        nxt(); rq2[1] = '0; or2 = '0; smp();                                   // cycle 7
        vec_cnt++; if (u_rr2.rr_ptr !== 1'b0) begin err_cnt++; $display("FAIL simul_rr_ptr got %0d want 0", u_rr2.rr_ptr); end
    endtask

    task automatic test_burst();
        nxt();
        rq2[0] = mk_req(64'h8000_3000, 1'b1, 8'd7);
        rq2[0].data = 64'hD000;
        rq2[1] = mk_req(64'h8000_4000, 1'b0, 8'd0);
        for (int b = 0; b < 8; b++) begin
            nxt();
            rq2[0].data = 64'hD000 + 64'(b);
            or2 = mk_beat(64'h0, (b == 7));
            smp();
            vec_cnt++; if (oq2.data !== 64'hD000 + 64'(b)) begin err_cnt++; $display("FAIL burst_data beat %0d got %h want %h", b, oq2.data, 64'hD000 + 64'(b)); end
            vec_cnt++; if (oq2.len !== 8'd7 || oq2.burst !== CBUS_BURST_INCR) begin err_cnt++; $display("FAIL burst_len beat %0d got %0d/%0d want 7/1", b, oq2.len, oq2.burst); end
            vec_cnt++; if (rs2[0].ready !== 1'b1) begin err_cnt++; $display("FAIL burst_ready0 beat %0d got %b want 1", b, rs2[0].ready); end
            vec_cnt++; if (rs2[1] !== '0) begin err_cnt++; $display("FAIL burst_resp1 beat %0d got %h want 0", b, rs2[1]); end
        end
        nxt(); rq2[0] = '0; or2 = '0; smp();
        vec_cnt++; if (oq2.valid !== 1'b0) begin err_cnt++; $display("FAIL burst_bubble valid got %b want 0", oq2.valid); end
        nxt(); smp();
        vec_cnt++; if (oq2.addr !== 64'h8000_4000) begin err_cnt++; $display("FAIL burst_switch addr got %h want 80004000", oq2.addr); end
        or2 = mk_beat(64'h0, 1'b1);
        nxt(); rq2[1] = '0; or2 = '0;
    endtask

    task automatic test_fairness();
        int exp_seq[9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
        nxt();
        for (int i = 0; i < 3; i++) rq3[i] = mk_req(64'h8001_0000 + 64'(i * 'h100), 1'b0, 8'd0);
        for (int k = 0; k < 9; k++) begin
            nxt(); or3 = mk_beat(64'(k), 1'b1); smp();
            vec_cnt++; if (oq3.addr !== 64'h8001_0000 + 64'(exp_seq[k] * 'h100)) begin err_cnt++; $display("FAIL fair_grant txn %0d addr got %h want owner %0d", k, oq3.addr, exp_seq[k]); end
            for (int j = 0; j < 3; j++) begin
                vec_cnt++; if (rs3[j].ready !== logic'(j == exp_seq[k])) begin err_cnt++; $display("FAIL fair_ready txn %0d port %0d got %b", k, j, rs3[j].ready); end
            end
            nxt(); or3 = '0; if (k == 8) rq3 = '0; smp();
            vec_cnt++; if (oq3.valid !== 1'b0) begin err_cnt++; $display("FAIL fair_bubble txn %0d valid got %b want 0", k, oq3.valid); end
        end
    endtask

    task automatic test_fixed();
        nxt();
        rqf[0] = mk_req(64'h8002_0000, 1'b0, 8'd0);
        rqf[1] = mk_req(64'h8002_0100, 1'b0, 8'd0);
        for (int k = 0; k < 4; k++) begin
            nxt(); orf = mk_beat(64'(k), 1'b1); smp();
            vec_cnt++; if (oqf.addr !== 64'h8002_0000 || rsf[0].ready !== 1'b1) begin err_cnt++; $display("FAIL fixed_grant txn %0d addr %h ready %b want 80020000/1", k, oqf.addr, rsf[0].ready); end
            vec_cnt++; if (rsf[1] !== '0) begin err_cnt++; $display("FAIL fixed_starve txn %0d resp1 got %h want 0", k, rsf[1]); end
            nxt(); orf = '0; if (k == 3) rqf = '0;
        end
    endtask

    task automatic test_reset_mid_burst();
        nxt(); rq2[0] = mk_req(64'h8000_0000, 1'b0, 8'd0);                      // advance rr_ptr to 1
        nxt(); or2 = mk_beat(64'h5, 1'b1);
        nxt(); rq2[0] = '0; or2 = '0; rq2[1] = mk_req(64'h8000_5000, 1'b0, 8'd7);
        for (int b = 0; b < 4; b++) begin
            nxt();
            or2 = mk_beat(64'(b), 1'b0);
            if (b == 3) reset = 1'b1;
            smp();
            if (b == 0) begin
                vec_cnt++; if (u_rr2.owner !== 1'b1 || u_rr2.rr_ptr !== 1'b1) begin err_cnt++; $display("FAIL rst_pre owner/rr_ptr got %0d/%0d want 1/1", u_rr2.owner, u_rr2.rr_ptr); end
            end
        end
        vec_cnt++; if (oq2 !== '0) begin err_cnt++; $display("FAIL rst_mid oreq got %h want 0", oq2); end
        vec_cnt++; if (rs2 !== '0) begin err_cnt++; $display("FAIL rst_mid iresps got %h want 0", rs2); end
        vec_cnt++; if (u_rr2.owner !== 1'b0 || u_rr2.rr_ptr !== 1'b0) begin err_cnt++; $display("FAIL rst_mid owner/rr_ptr got %0d/%0d want 0/0", u_rr2.owner, u_rr2.rr_ptr); end
        nxt(); rq2 = '0; or2 = '0;
        nxt(); reset = 1'b0;
        rq2[0] = mk_req(64'h8000_6000, 1'b0, 8'd0);
        rq2[1] = mk_req(64'h8000_7000, 1'b0, 8'd0);
        smp();
        vec_cnt++; if (oq2.valid !== 1'b0) begin err_cnt++; $display("FAIL rst_post idle valid got %b want 0", oq2.valid); end
        nxt(); smp();
        vec_cnt++; if (oq2.addr !== 64'h8000_6000) begin err_cnt++; $display("FAIL rst_post grant addr got %h want 80006000", oq2.addr); end
        or2 = mk_beat(64'h0, 1'b1);
        nxt(); rq2[0] = '0; or2 = '0;
        nxt(); smp();
        vec_cnt++; if (oq2.addr !== 64'h8000_7000) begin err_cnt++; $display("FAIL rst_post second addr got %h want 80007000", oq2.addr); end
        or2 = mk_beat(64'h0, 1'b1);
        nxt(); rq2 = '0; or2 = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_burst();
        test_fairness();
        test_fixed();
        test_reset_mid_burst();
        nxt();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
